dsram_confreg: RTL and testbench

- Responder end of the core's data SRAM interface (en/we/addr/wdata/rdata).
- Accepts one request per cycle and returns read data one cycle later.
- Decodes each access to either a local word RAM or a small config/peripheral register block: LEDs, switches, free-running timer with compare interrupt, and scratch.
- Sits at top level between the core's data port and board I/O, replacing a plain data RAM in functional-test builds.

---
 rtl/dsram_confreg.sv | 137 +++++++++++++
 tb/tb_dsram_confreg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dsram_confreg.sv
// rtl/dsram_confreg.sv - data SRAM responder: local word RAM plus config/peripheral register block
// Read data returns one cycle after the request; no stalls.
module dsram_confreg #(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        timer_irq
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;

  localparam logic [13:0] OFF_LED     = 14'h0;
  localparam logic [13:0] OFF_SWITCH  = 14'h1;
  localparam logic [13:0] OFF_TIMER   = 14'h2;
  localparam logic [13:0] OFF_CMP     = 14'h3;
  localparam logic [13:0] OFF_IRQ     = 14'h4;
  localparam logic [13:0] OFF_SCRATCH = 14'h5;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  logic [31:0] mem [0:RAM_DEPTH-1];
  logic [31:0] ram_q;
  logic        rd_ram_q;
  logic [31:0] conf_q;

  logic [15:0] led_q;
  logic [7:0]  sw_s1, sw_s2;
  logic [31:0] timer_q, cmp_q, scratch_q;
  logic        irq_q;

  logic              conf_sel, req_rd, req_wr, ram_rd, ram_wr;
  logic [13:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       conf_rdata;
  logic              wr_led, wr_timer, wr_cmp, wr_irq, wr_scratch;
  logic              irq_set, irq_clr;
  logic              unused_ok;

  assign conf_sel = (data_sram_addr[31:16] == CONF_HI);
  assign off      = data_sram_addr[15:2];
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign req_rd   = data_sram_en && (data_sram_we == 4'h0);
  assign req_wr   = data_sram_en && (data_sram_we != 4'h0);
  // Gating with resetn drops any request that coincides with reset.
  assign ram_rd   = req_rd && !conf_sel && resetn;
  assign ram_wr   = req_wr && !conf_sel && resetn;

  assign wr_led     = req_wr && conf_sel && (off == OFF_LED);
  assign wr_timer   = req_wr && conf_sel && (off == OFF_TIMER);
  assign wr_cmp     = req_wr && conf_sel && (off == OFF_CMP);
  assign wr_irq     = req_wr && conf_sel && (off == OFF_IRQ);
  assign wr_scratch = req_wr && conf_sel && (off == OFF_SCRATCH);

  assign irq_set = (timer_q == cmp_q);
  assign irq_clr = wr_irq && data_sram_we[0] && data_sram_wdata[0];

  assign unused_ok = ^data_sram_addr[1:0];

  always_comb begin
    conf_rdata = 32'h0;
    case (off)
      OFF_LED:     conf_rdata = {16'h0, led_q};
      OFF_SWITCH:  conf_rdata = {24'h0, sw_s2};
      OFF_TIMER:   conf_rdata = timer_q;
      OFF_CMP:     conf_rdata = cmp_q;
      OFF_IRQ:     conf_rdata = {31'h0, irq_q};
      OFF_SCRATCH: conf_rdata = scratch_q;
      default:     conf_rdata = 32'h0;
    endcase
  end

  // Block RAM: no reset on the array or its output register.
  always_ff @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_idx];
    for (int i = 0; i < 4; i++)
      if (ram_wr && data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ram_q  <= 1'b0;
      conf_q    <= 32'h0;
      led_q     <= 16'h0;
      sw_s1     <= 8'h0;
      sw_s2     <= 8'h0;
      timer_q   <= 32'h0;
      cmp_q     <= 32'hffff_ffff;
      irq_q     <= 1'b0;
      scratch_q <= 32'h0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;

      if (req_rd) begin
        rd_ram_q <= !conf_sel;
        if (conf_sel) conf_q <= conf_rdata;
      end

      if (wr_led) begin
        if (data_sram_we[0]) led_q[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) led_q[15:8] <= data_sram_wdata[15:8];
      end

      if (wr_timer) timer_q <= byte_merge(timer_q, data_sram_wdata, data_sram_we);
      else          timer_q <= timer_q + 32'd1;

      if (wr_cmp)     cmp_q     <= byte_merge(cmp_q, data_sram_wdata, data_sram_we);
      if (wr_scratch) scratch_q <= byte_merge(scratch_q, data_sram_wdata, data_sram_we);

      if (irq_set)      irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  // ram_q is unreset, so rd_ram_q steers to the reset conf_q until a RAM read lands.
  assign data_sram_rdata = rd_ram_q ? ram_q : conf_q;
  assign led             = led_q;
  assign timer_irq       = irq_q;

endmodule

// File: tb/tb_dsram_confreg.sv
// tb/tb_dsram_confreg.sv - scoreboard bench for dsram_confreg
module tb_dsram_confreg;

  localparam logic [31:0] A_LED     = 32'hbfaf_0000;
  localparam logic [31:0] A_SWITCH  = 32'hbfaf_0004;
  localparam logic [31:0] A_TIMER   = 32'hbfaf_0008;
  localparam logic [31:0] A_CMP     = 32'hbfaf_000c;
  localparam logic [31:0] A_IRQ     = 32'hbfaf_0010;
  localparam logic [31:0] A_SCRATCH = 32'hbfaf_0014;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch = 8'h0;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  dsram_confreg dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive stays for the edge, then any read issued is scored.
  task automatic step();
    logic        was_rd;
    logic [31:0] e;
    was_rd = data_sram_en && (data_sram_we == 4'h0);
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    if (was_rd) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rdata", data_sram_rdata, e);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    data_sram_en    = 1'b1;
    data_sram_we    = be;
    data_sram_addr  = a;
    data_sram_wdata = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    data_sram_en   = 1'b1;
    data_sram_we   = 4'h0;
    data_sram_addr = a;
    exp_q.push_back(e);
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", led, 32'h0);
    check("rst_irq", timer_irq, 32'h0);
    resetn = 1'b1;
    step();

    // RAM round trip and hold
    wr(32'h40, 32'h1234_5678, 4'hf);
    rd(32'h40, 32'h1234_5678);
    step();
    step();
    check("rdata_hold", data_sram_rdata, 32'h1234_5678);
    wr(32'h80, 32'hcafe_f00d, 4'hf);
    check("hold_on_write", data_sram_rdata, 32'h1234_5678);

    // byte lanes, aliasing, scratch
    wr(32'h40, 32'haabb_ccdd, 4'b0101);
    rd(32'h40, 32'h12bb_56dd);
    rd(32'h1040, 32'h12bb_56dd);
    rd(32'h80, 32'hcafe_f00d);
    wr(A_SCRATCH, 32'hffff_ffff, 4'b1000);
    rd(A_SCRATCH, 32'hff00_0000);

    // LED, switch, unmapped offset
    wr(A_LED, 32'hdead_beef, 4'hf);
    check("led", led, 32'h0000_beef);
    rd(A_LED, 32'h0000_beef);
    switch = 8'h5a;
    repeat (3) step();
    rd(A_SWITCH, 32'h0000_005a);
    wr(A_SWITCH, 32'hffff_ffff, 4'hf);
    rd(A_SWITCH, 32'h0000_005a);
    wr(32'hbfaf_0020, 32'h1111_1111, 4'hf);
    rd(32'hbfaf_0020, 32'h0);

    // timer wrap and compare interrupt
    wr(A_TIMER, 32'hffff_fffd, 4'hf);
    wr(A_CMP, 32'h0000_0001, 4'hf);
    rd(A_TIMER, 32'hffff_fffe);
    rd(A_TIMER, 32'hffff_ffff);
    rd(A_TIMER, 32'h0000_0000);
    check("irq_before_match", timer_irq, 32'h0);
    step();
    check("irq_rise", timer_irq, 32'h1);
    step();
    step();
    check("irq_sticky", timer_irq, 32'h1);
    wr(A_IRQ, 32'h0, 4'hf);
    check("irq_write0", timer_irq, 32'h1);
    rd(A_IRQ, 32'h1);
    wr(A_IRQ, 32'h1, 4'h1);
    check("irq_clear", timer_irq, 32'h0);
    rd(A_IRQ, 32'h0);

    // clear issued on the match edge: set wins
    wr(A_TIMER, 32'h0000_0050, 4'hf);
    wr(A_CMP, 32'h0000_0052, 4'hf);
    step();
    wr(A_IRQ, 32'h1, 4'h1);
    check("irq_set_wins", timer_irq, 32'h1);
    step();
    check("irq_set_hold", timer_irq, 32'h1);
    rd(A_CMP, 32'h0000_0052);

    // timer write suppresses increment
    wr(A_TIMER, 32'h0000_0100, 4'hf);
    rd(A_TIMER, 32'h0000_0100);
    rd(A_TIMER, 32'h0000_0101);
    wr(A_TIMER, 32'h0000_ab00, 4'b0010);
    rd(A_TIMER, 32'h0000_ab02);

    // async reset during a read
    check("pre_rst_irq", timer_irq, 32'h1);
    data_sram_en   = 1'b1;
    data_sram_we   = 4'h0;
    data_sram_addr = 32'h40;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rdata", data_sram_rdata, 32'h0);
    check("async_led", led, 32'h0);
    check("async_irq", timer_irq, 32'h0);
    data_sram_en = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("post_rst_rdata", data_sram_rdata, 32'h0);
    rd(A_TIMER, 32'h0);
    rd(A_TIMER, 32'h1);
    rd(A_CMP, 32'hffff_ffff);
    rd(A_LED, 32'h0);
    rd(A_SCRATCH, 32'h0);
    rd(A_IRQ, 32'h0);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
